// File: rtl/mpi_noc_out_arbiter.sv
// Packet-level arbiter merging N endpoint flit streams onto one NoC output link.
// Define MPI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; default is round-robin.
module mpi_noc_out_arbiter #(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int N              = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N*NOC_FLIT_WIDTH-1:0] in_flit,
  input  logic [N-1:0]                in_last,
  input  logic [N-1:0]                in_valid,
  output logic [N-1:0]                in_ready,
  output logic [NOC_FLIT_WIDTH-1:0]   out_flit,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0]                grant,
  output logic                        busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t        state;
  logic [IW-1:0] last_idx;
  logic [IW-1:0] owner_idx;
  logic [IW-1:0] idx;
  logic [N-1:0]  winner;
  logic          found;
  logic          handshake;

  // Winner search; the first valid requester in scan order takes the packet.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
`ifdef MPI_ARB_FIXED_PRIO_EN
      idx = IW'(k);
`else
      idx = IW'((int'(last_idx) + 1 + k) % N);
`endif
      if (!found && in_valid[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) owner_idx = IW'(i);
    end
  end

  // Grant is all-zero outside LOCKED, so gating with busy zeroes the idle outputs.
  assign busy      = (state == LOCKED);
  assign out_flit  = busy ? in_flit[int'(owner_idx)*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH] : '0;
  assign out_last  = busy & in_last[owner_idx];
  assign out_valid = busy & in_valid[owner_idx];
  assign in_ready  = grant & {N{out_ready}};
  assign handshake = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      last_idx <= IW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|in_valid) begin
            grant <= winner;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (handshake && out_last) begin
            last_idx <= owner_idx;
            grant    <= '0;
            state    <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpi_noc_out_arbiter.sv
// Scoreboard bench for mpi_noc_out_arbiter; expected flits are queued with owner as stimulus is loaded.
// Honours MPI_ARB_FIXED_PRIO_EN for the fixed-priority grant order.
module tb_mpi_noc_out_arbiter;
  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N*W-1:0] in_flit;
  logic [N-1:0]   in_last, in_valid, in_ready, grant;
  logic [W-1:0]   out_flit;
  logic           out_last, out_valid, out_ready, busy;

  always #5 clk = ~clk;

  mpi_noc_out_arbiter #(.NOC_FLIT_WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .grant(grant), .busy(busy)
  );

  typedef struct packed {
    logic [W-1:0] flit;
    logic         last;
  } src_t;

  typedef struct packed {
    logic [W-1:0] flit;
    logic         last;
    logic [N-1:0] owner;
  } exp_t;

  src_t src_q[N][$];
  exp_t sb[$];
  logic [N-1:0] hold;
  int vectors = 0;
  int miscompares = 0;
  logic [N-1:0] obs_grant, obs_ready;
  logic obs_busy, obs_hs, obs_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add(input int i, input logic [W-1:0] f, input logic l);
    src_t s;
    s.flit = f;
    s.last = l;
    src_q[i].push_back(s);
  endtask

  task automatic expect_flit(input logic [W-1:0] f, input logic l, input int o);
    exp_t e;
    e.flit  = f;
    e.last  = l;
    e.owner = '0;
    e.owner[o] = 1'b1;
    sb.push_back(e);
  endtask

  // One clock: drive at posedge+1, sample at the falling edge, retire accepted flits after the edge.
  task automatic cycle();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        in_flit[i*W +: W] = src_q[i][0].flit;
        in_last[i]        = src_q[i][0].last;
        in_valid[i]       = !hold[i];
      end else begin
        in_flit[i*W +: W] = '0;
        in_last[i]        = 1'b0;
        in_valid[i]       = 1'b0;
      end
    end
    #4;
    obs_grant = grant;
    obs_ready = in_ready;
    obs_busy  = busy;
    obs_valid = out_valid;
    obs_hs    = out_valid & out_ready;
    if (obs_hs) begin
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("flit %08h last %0b grant %b (expected %08h/%0b/%b)",
                 out_flit, out_last, grant, e.flit, e.last, e.owner);
        check("out_flit", 64'(out_flit), 64'(e.flit));
        check("out_last", 64'(out_last), 64'(e.last));
        check("owner", 64'(grant), 64'(e.owner));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (obs_ready[i] && in_valid[i]) void'(src_q[i].pop_front());
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    in_flit   = '0;
    in_last   = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    hold      = '0;

    // Reset state while rst is held low
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single 3-flit packet from requester 2
    add(2, 32'hA0, 1'b0); add(2, 32'hA1, 1'b0); add(2, 32'hA2, 1'b1);
    expect_flit(32'hA0, 1'b0, 2); expect_flit(32'hA1, 1'b0, 2); expect_flit(32'hA2, 1'b1, 2);
    cycle();
    check("t1_idle_grant", 64'(obs_grant), 64'd0);
    check("t1_idle_hs", 64'(obs_hs), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t1_grant", 64'(obs_grant), 64'b0100);
      check("t1_hs", 64'(obs_hs), 64'd1);
    end
    cycle();
    check("t1_end_grant", 64'(obs_grant), 64'd0);
    check("t1_end_busy", 64'(obs_busy), 64'd0);

    // Four continuous requesters, two single-flit packets each
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      add(i, 32'h40 + 32'(i*16), 1'b1);
      add(i, 32'h41 + 32'(i*16), 1'b1);
    end
`ifdef MPI_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 2; p++) expect_flit(32'h40 + 32'(i*16 + p), 1'b1, i);
`else
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) expect_flit(32'h40 + 32'(i*16 + p), 1'b1, i);
`endif
    for (int k = 0; k < 16; k++) begin
      cycle();
      check("t2_hs_pattern", 64'(obs_hs), 64'(k % 2));
    end

    // Backpressure and owner gap with requester 3 waiting
    add(1, 32'h10, 1'b0); add(1, 32'h11, 1'b1); add(3, 32'h3A, 1'b1);
    expect_flit(32'h10, 1'b0, 1); expect_flit(32'h11, 1'b1, 1); expect_flit(32'h3A, 1'b1, 3);
    out_ready = 1'b0;
    cycle();
    check("t3_idle_grant", 64'(obs_grant), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t3_bp_grant", 64'(obs_grant), 64'b0010);
      check("t3_bp_ready", 64'(obs_ready), 64'b0000);
      check("t3_bp_valid", 64'(obs_valid), 64'd1);
    end
    out_ready = 1'b1;
    hold[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("t3_gap_grant", 64'(obs_grant), 64'b0010);
      check("t3_gap_ready", 64'(obs_ready), 64'b0010);
      check("t3_gap_valid", 64'(obs_valid), 64'd0);
    end
    hold[1] = 1'b0;
    cycle(); check("t3_f0_hs", 64'(obs_hs), 64'd1);
    cycle(); check("t3_f1_hs", 64'(obs_hs), 64'd1);
    cycle(); check("t3_rearb_grant", 64'(obs_grant), 64'd0);
    cycle(); check("t3_r3_grant", 64'(obs_grant), 64'b1000);
    cycle();

    // Reset in the middle of a packet; requester 1 first so last_idx is not N-1
    add(1, 32'h51, 1'b1); expect_flit(32'h51, 1'b1, 1);
    cycle(); cycle();
    for (int k = 0; k < 4; k++) add(2, 32'hC0 + 32'(k), 1'(k == 3));
    expect_flit(32'hC0, 1'b0, 2);
    cycle();
    cycle(); check("t4_c0_grant", 64'(obs_grant), 64'b0100);
    rst = 1'b0;
    #1;
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_grant", 64'(grant), 64'd0);
    check("t4_rst_valid", 64'(out_valid), 64'd0);
    check("t4_rst_last", 64'(out_last), 64'd0);
    check("t4_rst_flit", 64'(out_flit), 64'd0);
    check("t4_rst_ready", 64'(in_ready), 64'd0);
    src_q[2].delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    add(0, 32'hE0, 1'b1); add(1, 32'hE1, 1'b1); add(2, 32'hE2, 1'b1);
    expect_flit(32'hE0, 1'b1, 0); expect_flit(32'hE1, 1'b1, 1); expect_flit(32'hE2, 1'b1, 2);
    cycle();
    cycle(); check("t4_restart_grant", 64'(obs_grant), 64'b0001);
    for (int k = 0; k < 4; k++) cycle();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
